dec138_rr_sched: RTL and testbench

Round-robin scheduler that shares one `ic_74138` 3-to-8 decoder among eight requesters. Each requester gets an exclusive active-low select line for a bounded number of cycles. The block registers the decoder's select (`a`,`b`,`c`) and enable (`g1`,`g2a`,`g2b`) inputs. It sequences them so the select code is always stable before the enable asserts, which gives glitch-free chip-select generation for a shared bus or bank.

---
 rtl/dec138_pkg.sv | 17 +
 rtl/dec138_rr_sched_if.sv | 32 +++
 rtl/ic_74138.sv | 23 ++
 rtl/dec138_rr_sched.sv | 149 ++++++++++++++
 tb/tb_dec138_rr_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dec138_pkg.sv
// Purpose: shared types and sizes for the round-robin 74138 scheduler.
//   DEC_N  : number of decoder outputs / requesters
//   SEL_W  : width of the decoder select code {c,b,a}
//   state_t: scheduler state encoding (2 bits)
package dec138_pkg;

    localparam int unsigned DEC_N = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/dec138_rr_sched_if.sv
// Purpose: request/decoder bundle between requesters and the scheduler.
//   req        : per-requester request (requester side drives)
//   g1/g2a/g2b : decoder enables (scheduler drives)
//   a/b/c      : decoder select, a = LSB (scheduler drives)
//   y_n        : active-low select lines (scheduler drives)
//   gnt_id     : currently selected requester {c,b,a}
//   busy       : scheduler not idle
interface dec138_rr_sched_if;
    import dec138_pkg::*;

    logic [DEC_N-1:0] req;
    logic             g1;
    logic             g2a;
    logic             g2b;
    logic             a;
    logic             b;
    logic             c;
    logic [DEC_N-1:0] y_n;
    logic [SEL_W-1:0] gnt_id;
    logic             busy;

    modport master (
        output req,
        input  g1, g2a, g2b, a, b, c, y_n, gnt_id, busy
    );

    modport slave (
        input  req,
        output g1, g2a, g2b, a, b, c, y_n, gnt_id, busy
    );

endinterface

// File: rtl/ic_74138.sv
// Purpose: behavioural model of the 74138 3-to-8 line decoder.
//   g1, g2a, g2b : enables (g1 active-high, g2a/g2b active-low)
//   a, b, c      : select inputs, a = LSB
//   y            : active-low outputs; all high when disabled
module ic_74138 (
    input  logic       g1,
    input  logic       g2a,
    input  logic       g2b,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] y
);

    // One output low only when fully enabled.
    always_comb begin
        y = 8'hFF;
        if (g1 && !g2a && !g2b) begin
            y[{c, b, a}] = 1'b0;
        end
    end

endmodule

// File: rtl/dec138_rr_sched.sv
// Purpose: round-robin scheduler sharing one 74138 among eight requesters.
//   Select code is loaded in IDLE and enable is raised one cycle later, so
//   the code is always stable while the decoder is enabled.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of dec138_rr_sched_if (req in; enables, select,
//           y_n, gnt_id, busy out)
//   HOLD_MAX (1..15): max consecutive enabled cycles per grant
//   GAP      (0..7) : idle turnaround cycles after each grant
module dec138_rr_sched
    import dec138_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned GAP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dec138_rr_sched_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 3;

    state_t           state, state_nxt;
    logic             en, en_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;
    logic [SEL_W-1:0] last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [DEC_N-1:0] req;
    logic [DEC_N-1:0] y;

    // Rotate so that last+1 sits at bit 0, then take the lowest set bit.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [DEC_N-1:0] r,
                                                 input logic [SEL_W-1:0] prev);
        logic [SEL_W-1:0] start;
        logic [DEC_N-1:0] rot;
        logic [SEL_W-1:0] off;
        logic             found;
        start = prev + SEL_W'(1);
        rot   = DEC_N'({r, r} >> start);
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < DEC_N; k++) begin
            if (!found && rot[k]) begin
                off   = SEL_W'(k);
                found = 1'b1;
            end
        end
        return start + off;
    endfunction

    assign req = bus.req;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            en      <= 1'b0;
            sel     <= '0;
            last    <= SEL_W'(7);
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            en      <= en_nxt;
            sel     <= sel_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        en_nxt      = en;
        sel_nxt     = sel;
        last_nxt    = last;
        cnt_nxt     = cnt;
        gap_cnt_nxt = gap_cnt;
        case (state)
            ST_IDLE: begin
                en_nxt = 1'b0;
                if (|req) begin
                    sel_nxt   = rr_pick(req, last);
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (req[sel]) begin
                    en_nxt    = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    last_nxt  = sel;
                    state_nxt = ST_GRANT;
                end else begin
                    en_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[sel] || (cnt == CNT_W'(HOLD_MAX))) begin
                    en_nxt = 1'b0;
                    if (GAP == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        gap_cnt_nxt = GAP_W'(1);
                        state_nxt   = ST_GAP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                en_nxt = 1'b0;
                if (gap_cnt >= GAP_W'(GAP)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                en_nxt    = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    ic_74138 u_dec (
        .g1  (en),
        .g2a (~en),
        .g2b (~en),
        .a   (sel[0]),
        .b   (sel[1]),
        .c   (sel[2]),
        .y   (y)
    );

    assign bus.g1     = en;
    assign bus.g2a    = ~en;
    assign bus.g2b    = ~en;
    assign bus.a      = sel[0];
    assign bus.b      = sel[1];
    assign bus.c      = sel[2];
    assign bus.y_n    = y;
    assign bus.gnt_id = sel;
    assign bus.busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_dec138_rr_sched.sv
// Purpose: directed self-checking bench for dec138_rr_sched (HOLD_MAX=4, GAP=1).
module tb_dec138_rr_sched;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dec138_rr_sched_if bus ();

    dec138_rr_sched #(
        .HOLD_MAX (4),
        .GAP      (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset, then release on a falling edge; the next rising edge is E1.
    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.y_n !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_y_n: got %h want ff", bus.y_n);
        end
        vectors++;
        if ({bus.g1, bus.g2a, bus.g2b} !== 3'b011) begin
            miscompares++;
            $display("FAIL reset_enables: got %b want 011", {bus.g1, bus.g2a, bus.g2b});
        end
        vectors++;
        if ({bus.c, bus.b, bus.a} !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_select: got %0d want 0", {bus.c, bus.b, bus.a});
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        vectors++;
        if (bus.gnt_id !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_gnt_id: got %0d want 0", bus.gnt_id);
        end
    endtask

    // req=01 held: SETUP, 4 enabled, GAP, IDLE, SETUP, then enabled again.
    task automatic test_single_held();
        logic [7:0] exp_y [12] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF,
                                   8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        logic       exp_b [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        bus.req = 8'h01;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.y_n !== exp_y[i]) begin
                miscompares++;
                $display("FAIL single_y_n[%0d]: got %h want %h", i, bus.y_n, exp_y[i]);
            end
            vectors++;
            if (bus.busy !== exp_b[i]) begin
                miscompares++;
                $display("FAIL single_busy[%0d]: got %b want %b", i, bus.busy, exp_b[i]);
            end
        end
    endtask

    // req=FF held: grants 0..7 then 0, each a 7-cycle period with 4 low cycles.
    task automatic test_all_requesting();
        int         p;
        int         g;
        logic [7:0] exp_y;
        do_reset();
        bus.req = 8'hFF;
        for (int k = 1; k <= 63; k++) begin
            @(posedge clk);
            @(negedge clk);
            p = (k - 1) % 7;
            g = ((k - 1) / 7) % 8;
            exp_y = (p >= 1 && p <= 4) ? ~(8'h01 << g) : 8'hFF;
            vectors++;
            if (bus.y_n !== exp_y) begin
                miscompares++;
                $display("FAIL all_y_n[edge %0d]: got %h want %h", k, bus.y_n, exp_y);
            end
            if (p == 0) begin
                vectors++;
                if (bus.gnt_id !== 3'(g)) begin
                    miscompares++;
                    $display("FAIL all_gnt_id[edge %0d]: got %0d want %0d", k, bus.gnt_id, g);
                end
            end
            vectors++;
            if ($countones(~bus.y_n) > 1) begin
                miscompares++;
                $display("FAIL all_one_low[edge %0d]: got %h want at most one low", k, bus.y_n);
            end
        end
    endtask

    // req=08 granted, dropped after 2 enabled cycles while 7 and 0 wait.
    task automatic test_early_release();
        logic [7:0] exp_y [14] = '{8'hFF, 8'hF7, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'h7F,
                                   8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
        do_reset();
        bus.req = 8'h08;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.y_n !== exp_y[i]) begin
                miscompares++;
                $display("FAIL early_y_n[%0d]: got %h want %h", i, bus.y_n, exp_y[i]);
            end
            if (i == 0 || i == 5 || i == 12) begin
                vectors++;
                if (bus.gnt_id !== ((i == 0) ? 3'd3 : (i == 5) ? 3'd7 : 3'd0)) begin
                    miscompares++;
                    $display("FAIL early_gnt_id[%0d]: got %0d want %0d", i, bus.gnt_id,
                             (i == 0) ? 3 : (i == 5) ? 7 : 0);
                end
            end
            if (i == 2) bus.req = 8'h81;
        end
    endtask

    // req[5] for one cycle aborts in SETUP; last stays 7, so 0 beats 6 afterwards.
    task automatic test_abort_setup();
        do_reset();
        bus.req = 8'h20;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.gnt_id !== 3'd5 || bus.y_n !== 8'hFF) begin
            miscompares++;
            $display("FAIL abort_setup: got busy=%b id=%0d y_n=%h want busy=1 id=5 y_n=ff",
                     bus.busy, bus.gnt_id, bus.y_n);
        end
        bus.req = 8'h00;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.y_n !== 8'hFF) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b y_n=%h want busy=0 y_n=ff", bus.busy, bus.y_n);
        end
        bus.req = 8'h41;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.gnt_id !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_next_id: got %0d want 0", bus.gnt_id);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.y_n !== 8'hFE) begin
            miscompares++;
            $display("FAIL abort_next_y_n: got %h want fe", bus.y_n);
        end
    endtask

    // Asynchronous reset during a grant of requester 2.
    task automatic test_reset_mid();
        do_reset();
        bus.req = 8'h04;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (bus.y_n !== 8'hFB) begin
            miscompares++;
            $display("FAIL mid_pre_y_n: got %h want fb", bus.y_n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.y_n !== 8'hFF || bus.g1 !== 1'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_async: got y_n=%h g1=%b busy=%b id=%0d want ff 0 0 0",
                     bus.y_n, bus.g1, bus.busy, bus.gnt_id);
        end
        bus.req = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.gnt_id !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_after_id: got %0d want 0", bus.gnt_id);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.y_n !== 8'hFE) begin
            miscompares++;
            $display("FAIL mid_after_y_n: got %h want fe", bus.y_n);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.req     = 8'h00;
        test_reset();
        test_single_held();
        test_all_requesting();
        test_early_release();
        test_abort_setup();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
